// File: rtl/reg_display_scanner.sv
// reg_display_scanner
//   Shows one 16-bit half-word of the R2/R3 debug taps in hex on a 4-digit
//   multiplexed, active-low 7-segment display. A snapshot of the selected
//   half-word is taken once per frame, so the digits of a frame never tear.
//
// Ports
//   CLK     in   1   system clock, all state on posedge
//   RST     in   1   asynchronous, active-high reset
//   iR2     in  32   register R2 observation bus
//   iR3     in  32   register R3 observation bus
//   iSel    in   2   00=R2[15:0] 01=R2[31:16] 10=R3[15:0] 11=R3[31:16]
//   iBlank  in   1   1 = all anodes off; scanning continues underneath
//   oAN     out  4   digit anodes, active-low, oAN[0] = rightmost digit
//   oSEG    out  7   segments {g,f,e,d,c,b,a}, active-low
//   oDP     out  1   decimal point, active-low (lit on digit 0 for upper halves)
//   oFrame  out  1   one-cycle pulse after each snapshot capture
module reg_display_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = 17
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] iR2,
  input  logic [31:0] iR3,
  input  logic [1:0]  iSel,
  input  logic        iBlank,
  output logic [3:0]  oAN,
  output logic [6:0]  oSEG,
  output logic        oDP,
  output logic        oFrame
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] count_reg, count_next;
  logic [1:0]       digit_reg, digit_next;
  logic [15:0]      snap_reg, snap_next;
  logic             dpsel_reg, dpsel_next;
  logic             tick;
  logic             capture;
  logic [15:0]      sel_half;
  logic [3:0]       nibble;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic             dp_next;

  assign tick = (count_reg == DIV_LAST);

  always_comb begin
    case (iSel)
      2'b00:   sel_half = iR2[15:0];
      2'b01:   sel_half = iR2[31:16];
      2'b10:   sel_half = iR3[15:0];
      default: sel_half = iR3[31:16];
    endcase
  end

  // Next-state, capture and next-output decode. Segments and decimal point
  // are decoded from the next digit/snapshot so a new frame's digit 0 appears
  // on the very edge it is captured; they only change on slot boundaries.
  always_comb begin
    state_next = state_reg;
    count_next = tick ? '0 : count_reg + 1'b1;
    digit_next = digit_reg;
    snap_next  = snap_reg;
    dpsel_next = dpsel_reg;
    capture    = 1'b0;

    if (tick) begin
      if (state_reg == IDLE || digit_reg == 2'd3) begin
        state_next = SCAN;
        capture    = 1'b1;
        snap_next  = sel_half;
        dpsel_next = iSel[0];
        digit_next = 2'd0;
      end else begin
        digit_next = digit_reg + 2'd1;
      end
    end

    nibble = snap_next[{digit_next, 2'b00} +: 4];
    case (nibble)
      4'h0: seg_next = 7'h40;
      4'h1: seg_next = 7'h79;
      4'h2: seg_next = 7'h24;
      4'h3: seg_next = 7'h30;
      4'h4: seg_next = 7'h19;
      4'h5: seg_next = 7'h12;
      4'h6: seg_next = 7'h02;
      4'h7: seg_next = 7'h78;
      4'h8: seg_next = 7'h00;
      4'h9: seg_next = 7'h10;
      4'hA: seg_next = 7'h08;
      4'hB: seg_next = 7'h03;
      4'hC: seg_next = 7'h46;
      4'hD: seg_next = 7'h21;
      4'hE: seg_next = 7'h06;
      default: seg_next = 7'h0E;
    endcase

    dp_next = ~((digit_next == 2'd0) && dpsel_next);

    // Anodes react to blanking on any edge; the display stays dark until the
    // first frame has been captured.
    if (iBlank || state_next == IDLE)
      an_next = 4'hF;
    else
      an_next = ~(4'b0001 << digit_next);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      count_reg <= '0;
      digit_reg <= 2'd0;
      snap_reg  <= 16'h0;
      dpsel_reg <= 1'b0;
      oAN       <= 4'hF;
      oSEG      <= 7'h7F;
      oDP       <= 1'b1;
      oFrame    <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      digit_reg <= digit_next;
      snap_reg  <= snap_next;
      dpsel_reg <= dpsel_next;
      oAN       <= an_next;
      oFrame    <= capture;
      if (tick) begin
        oSEG <= seg_next;
        oDP  <= dp_next;
      end
    end
  end

endmodule
